// File: rtl/mmio_pkg.sv
// Shared register-map constants and address decode for the UART MMIO block.
// Decode looks only at the low byte; the region is qualified upstream.
package mmio_pkg;

  localparam logic [7:0] MMIO_STATUS = 8'h00;
  localparam logic [7:0] MMIO_RX     = 8'h04;
  localparam logic [7:0] MMIO_TX     = 8'h08;
  localparam logic [7:0] MMIO_CYC    = 8'h10;
  localparam logic [7:0] MMIO_INST   = 8'h14;
  localparam logic [7:0] MMIO_CLR    = 8'h18;

  localparam int STAT_TX_NOT_FULL  = 0;
  localparam int STAT_RX_NOT_EMPTY = 1;
  localparam int STAT_RX_OVERFLOW  = 2;

  typedef enum logic [2:0] {
    REG_STATUS,
    REG_RX,
    REG_TX,
    REG_CYC,
    REG_INST,
    REG_CLR,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode(input logic [7:0] offset);
    case (offset)
      MMIO_STATUS: return REG_STATUS;
      MMIO_RX:     return REG_RX;
      MMIO_TX:     return REG_TX;
      MMIO_CYC:    return REG_CYC;
      MMIO_INST:   return REG_INST;
      MMIO_CLR:    return REG_CLR;
      default:     return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through head; push to full and pop from empty
// are ignored, so callers may present raw requests.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // validity, and leaving the array reset-free lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front end: RX/TX byte FIFOs, status, and cycle and
// instruction counters, with registered one-cycle read data like dmem.
module uart_mmio_fifo
  import mmio_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic        io_re,
  input  logic [3:0]  io_we,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic        inst_retire,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready
);

  reg_sel_e    sel;
  logic        any_we;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  rx_head, tx_head;
  logic        rx_overflow;
  logic        clr_cnt;
  logic [31:0] cyc_cnt, inst_cnt;
  logic [31:0] rd_next;
  logic        unused_bits;

  assign unused_bits = ^{io_addr[31:8], io_wdata[31:8]};

  assign sel    = decode(io_addr[7:0]);
  assign any_we = |io_we;

  // Ready is forced low during reset so the receiver never hands over a byte
  // that the reset would discard.
  assign uart_rx_ready = !rx_full && !rst;
  assign rx_push       = uart_rx_valid && uart_rx_ready;
  assign rx_pop        = io_re && (sel == REG_RX);

  assign tx_push       = io_we[0] && (sel == REG_TX);
  assign uart_tx_valid = !tx_empty && !rst;
  assign uart_tx_data  = uart_tx_valid ? tx_head : 8'h00;
  assign tx_pop        = uart_tx_valid && uart_tx_ready;

  assign clr_cnt = any_we && (sel == REG_CLR);

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (uart_rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (io_wdata[7:0]),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // A new overflow event outranks a simultaneous clear so it is never missed.
  always_ff @(posedge clk) begin
    if (rst)                                 rx_overflow <= 1'b0;
    else if (uart_rx_valid && rx_full)       rx_overflow <= 1'b1;
    else if (any_we && (sel == REG_STATUS))  rx_overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
    end
  end

  // NOTE: default assignment first so no path through the case leaves
  // rd_next unassigned and infers a latch.
  always_comb begin
    rd_next = '0;
    case (sel)
      REG_STATUS: begin
        rd_next[STAT_TX_NOT_FULL]  = !tx_full;
        rd_next[STAT_RX_NOT_EMPTY] = !rx_empty;
        rd_next[STAT_RX_OVERFLOW]  = rx_overflow;
      end
      REG_RX:   rd_next[7:0] = rx_empty ? 8'h00 : rx_head;
      REG_CYC:  rd_next = cyc_cnt;
      REG_INST: rd_next = inst_cnt;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        io_rdata <= '0;
    else if (io_re) io_rdata <= rd_next;
    else            io_rdata <= '0;
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Self-checking bench: vector table, directed corner sequences, then random
// traffic compared against a queue-based model of the register map.
module tb_uart_mmio_fifo;
  import mmio_pkg::*;

  localparam int RXD = 8;
  localparam int TXD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] io_addr;
  logic        io_re;
  logic [3:0]  io_we;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        inst_retire;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;

  always #5 clk = ~clk;

  uart_mmio_fifo #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk           (clk),
    .rst           (rst),
    .io_addr       (io_addr),
    .io_re         (io_re),
    .io_we         (io_we),
    .io_wdata      (io_wdata),
    .io_rdata      (io_rdata),
    .inst_retire   (inst_retire),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic re, input logic [3:0] we, input logic [7:0] off,
                       input logic [31:0] wd, input logic rxv, input logic [7:0] rxd,
                       input logic txr, input logic ret);
    io_re         = re;
    io_we         = we;
    io_addr       = {24'h800000, off};
    io_wdata      = wd;
    uart_rx_valid = rxv;
    uart_rx_data  = rxd;
    uart_tx_ready = txr;
    inst_retire   = ret;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
    drive(1'b1, 4'h0, off, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    check(name, io_rdata, exp);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd, input logic txr);
    drive(1'b0, 4'h1, off, wd, 1'b0, 8'h00, txr, 1'b0);
    tick();
  endtask

  typedef struct {
    logic        re;
    logic [3:0]  we;
    logic [7:0]  off;
    logic [7:0]  wd;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic [31:0] exp_rdata;
    logic        exp_txv;
    logic [7:0]  exp_txd;
    logic        exp_rxr;
  } vec_t;

  vec_t vecs[13];

  logic [7:0] offs[8] = '{MMIO_STATUS, MMIO_RX, MMIO_TX, 8'h0C, MMIO_CYC, MMIO_INST, MMIO_CLR, 8'h1C};

  // Reference model state
  logic [7:0]  mq_rx[$];
  logic [7:0]  mq_tx[$];
  logic        m_ovf;
  logic [31:0] m_cyc, m_inst;

  logic pending, accepted;

  initial begin
    //                re we    off    wd     rxv rxd    txr  rdata   txv txd    rxr
    vecs[0]  = '{1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 32'h1,  1'b0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 4'h1, 8'h08, 8'h41, 1'b0, 8'h00, 1'b0, 32'h0,  1'b0, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 4'h1, 8'h08, 8'h42, 1'b0, 8'h00, 1'b0, 32'h0,  1'b1, 8'h41, 1'b1};
    vecs[3]  = '{1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 32'h1,  1'b1, 8'h41, 1'b1};
    vecs[4]  = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 32'h0,  1'b1, 8'h41, 1'b1};
    vecs[5]  = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 32'h0,  1'b1, 8'h42, 1'b1};
    vecs[6]  = '{1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 32'h0,  1'b0, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 4'h0, 8'h04, 8'h00, 1'b1, 8'h5A, 1'b0, 32'h0,  1'b0, 8'h00, 1'b1};
    vecs[8]  = '{1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 32'h3,  1'b0, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, 4'h0, 8'h04, 8'h00, 1'b0, 8'h00, 1'b0, 32'h5A, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{1'b1, 4'h0, 8'h04, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0,  1'b0, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 4'hF, 8'h0C, 8'hFF, 1'b0, 8'h00, 1'b0, 32'h0,  1'b0, 8'h00, 1'b1};
    vecs[12] = '{1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 32'h1,  1'b0, 8'h00, 1'b1};

    // Reset values
    rst = 1'b1;
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check("reset io_rdata", io_rdata, 32'h0);
    check("reset tx_valid", uart_tx_valid, 1'b0);
    check("reset tx_data", uart_tx_data, 8'h00);
    check("reset rx_ready", uart_rx_ready, 1'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].re, vecs[i].we, vecs[i].off, {24'h0, vecs[i].wd},
            vecs[i].rxv, vecs[i].rxd, vecs[i].txr, 1'b0);
      #1;
      check($sformatf("vec%0d tx_valid", i), uart_tx_valid, vecs[i].exp_txv);
      if (vecs[i].exp_txv) check($sformatf("vec%0d tx_data", i), uart_tx_data, vecs[i].exp_txd);
      check($sformatf("vec%0d rx_ready", i), uart_rx_ready, vecs[i].exp_rxr);
      tick();
      check($sformatf("vec%0d io_rdata", i), io_rdata, vecs[i].exp_rdata);
    end

    // RX overflow: nine bytes into an eight-entry FIFO
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      #1;
      check($sformatf("ovf rx_ready byte%0d", i), uart_rx_ready, i < 8);
      tick();
    end
    drive(1'b1, 4'h0, MMIO_STATUS, 32'h0, 1'b1, 8'h18, 1'b0, 1'b0);
    tick();
    check("ovf status", io_rdata, 32'h7);
    pending = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 4'h0, MMIO_RX, 32'h0, pending, 8'h18, 1'b0, 1'b0);
      #1;
      accepted = pending && uart_rx_ready;
      tick();
      if (accepted) pending = 1'b0;
      check($sformatf("ovf rx read%0d", i), io_rdata, 32'(8'h10 + i));
    end
    check("ovf byte 0x18 accepted", pending, 1'b0);
    rd(MMIO_STATUS, 32'h5, "ovf sticky status");
    wr(MMIO_STATUS, 32'h0, 1'b0);
    rd(MMIO_STATUS, 32'h1, "ovf cleared status");

    // Counters
    wr(MMIO_CLR, 32'h0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, i < 37);
      tick();
    end
    rd(MMIO_CYC, 32'd100, "cycle count");
    rd(MMIO_INST, 32'd37, "instr count");
    drive(1'b0, 4'h1, MMIO_CLR, 32'h0, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    rd(MMIO_CYC, 32'd0, "cycle after clear");
    rd(MMIO_INST, 32'd0, "instr after clear");
    rd(MMIO_CYC, 32'd2, "cycle restarted");

    // TX full: dropped push, then simultaneous pop+push at full
    for (int i = 0; i < 8; i++) wr(MMIO_TX, 32'(8'hA0 + i), 1'b0);
    rd(MMIO_STATUS, 32'h0, "tx full status");
    wr(MMIO_TX, 32'h99, 1'b0);
    drive(1'b0, 4'h1, MMIO_TX, 32'h98, 1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    check("full pop+push tx_data", uart_tx_data, 8'hA0);
    tick();
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0);
      #1;
      check($sformatf("drain%0d tx_valid", i), uart_tx_valid, 1'b1);
      check($sformatf("drain%0d tx_data", i), uart_tx_data, 32'(8'hA0 + i));
      tick();
    end
    check("drain done tx_valid", uart_tx_valid, 1'b0);

    // Reset in the middle of traffic
    drive(1'b0, 4'h1, MMIO_TX, 32'h55, 1'b1, 8'h66, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    check("midrst tx_valid", uart_tx_valid, 1'b0);
    check("midrst tx_data", uart_tx_data, 8'h00);
    check("midrst rx_ready", uart_rx_ready, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("postrst tx_valid", uart_tx_valid, 1'b0);
    rd(MMIO_STATUS, 32'h1, "postrst status");
    rd(MMIO_RX, 32'h0, "postrst rx empty");

    // Randomized traffic against the queue model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq_rx.delete();
    mq_tx.delete();
    m_ovf  = 1'b0;
    m_cyc  = '0;
    m_inst = '0;
    for (int n = 0; n < 600; n++) begin
      logic        re, rxv, txr, ret, exp_rxr, exp_txv, tx_full_pre;
      logic [3:0]  we;
      logic [7:0]  off, rxd, wd;
      logic [31:0] exp_rd;
      int          k;

      k = $urandom_range(0, 7);
      if (k == 6 && $urandom_range(0, 9) != 0) k = 4;
      off = offs[k];
      re  = 1'($urandom_range(0, 1));
      we  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      wd  = 8'($urandom);
      rxd = 8'($urandom);
      rxv = (n < 300) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
      txr = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      ret = 1'($urandom_range(0, 1));
      if (off == MMIO_STATUS && we != 4'h0) rxv = 1'b0;

      exp_rxr     = mq_rx.size() < RXD;
      exp_txv     = mq_tx.size() != 0;
      tx_full_pre = mq_tx.size() >= TXD;

      drive(re, we, off, {24'h0, wd}, rxv, rxd, txr, ret);
      #1;
      check($sformatf("rnd%0d rx_ready", n), uart_rx_ready, exp_rxr);
      check($sformatf("rnd%0d tx_valid", n), uart_tx_valid, exp_txv);
      if (exp_txv) check($sformatf("rnd%0d tx_data", n), uart_tx_data, mq_tx[0]);

      exp_rd = 32'h0;
      if (re) begin
        case (off)
          MMIO_STATUS: exp_rd = {29'b0, m_ovf, mq_rx.size() != 0, !tx_full_pre};
          MMIO_RX:     exp_rd = (mq_rx.size() != 0) ? 32'(mq_rx[0]) : 32'h0;
          MMIO_CYC:    exp_rd = m_cyc;
          MMIO_INST:   exp_rd = m_inst;
          default:     exp_rd = 32'h0;
        endcase
      end

      if (re && off == MMIO_RX && mq_rx.size() != 0) void'(mq_rx.pop_front());
      if (rxv && exp_rxr) mq_rx.push_back(rxd);
      if (rxv && !exp_rxr) m_ovf = 1'b1;
      else if (we != 4'h0 && off == MMIO_STATUS) m_ovf = 1'b0;
      if (exp_txv && txr) void'(mq_tx.pop_front());
      if (we[0] && off == MMIO_TX && !tx_full_pre) mq_tx.push_back(wd);
      if (we != 4'h0 && off == MMIO_CLR) begin
        m_cyc  = '0;
        m_inst = '0;
      end else begin
        m_cyc = m_cyc + 32'd1;
        if (ret) m_inst = m_inst + 32'd1;
      end

      tick();
      check($sformatf("rnd%0d io_rdata", n), io_rdata, exp_rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
